// File: rtl/flash_pkg.sv
// flash_pkg: flash command opcodes, sequencer state encodings and sizing helper
package flash_pkg;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_BE   = 8'hC7;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WREN_FRM = 2'd1;
    localparam logic [1:0] GAP      = 2'd2;
    localparam logic [1:0] BE_FRM   = 2'd3;
    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_SHIFT = 2'd1;
    localparam logic [1:0] PH_HOLD  = 2'd2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction
endpackage

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: mode-0 MSB-first byte shifter; load presets mosi to bit7, start begins clocking
module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       load,
    input  logic       start,
    input  logic [7:0] data,
    output logic       sck,
    output logic       mosi,
    output logic       byte_done
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);

    logic [6:0]    sr;
    logic [DW-1:0] cnt;
    logic [2:0]    bits;
    logic          active;

    // asserted in the cycle before the final sck fall so the caller can start its hold count on that edge
    assign byte_done = active && sck && cnt == DIV_END && bits == 3'd7;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr     <= '0;
            cnt    <= '0;
            bits   <= '0;
            active <= 1'b0;
            sck    <= 1'b0;
            mosi   <= 1'b0;
        end else begin
            if (load) begin
                sr   <= data[6:0];
                mosi <= data[7];
            end
            if (start) begin
                active <= 1'b1;
                cnt    <= '0;
                bits   <= '0;
            end else if (active) begin
                if (cnt != DIV_END) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                    sck <= !sck;
                    if (sck) begin
                        if (bits == 3'd7) begin
                            active <= 1'b0;
                        end else begin
                            bits <= bits + 1'b1;
                            sr   <= {sr[5:0], 1'b0};
                            mosi <= sr[6];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: rtl/flash_be_ctrl.sv
// flash_be_ctrl: on key_flag issues WREN then BE to a SPI NOR flash in separate chip-select frames
module flash_be_ctrl
    import flash_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    output logic cs_n,
    output logic sck,
    output logic mosi,
    output logic busy,
    output logic done
);
    localparam int CW = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);
    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP - 1);

    logic [1:0]    state, phase;
    logic [CW-1:0] cnt;
    logic [7:0]    load_data;
    logic          in_frame, go, frame_end, start, load, byte_done;

    // a request landing on the done cycle is dropped: the sequence counts as still finishing
    always_comb begin
        in_frame  = state == WREN_FRM || state == BE_FRM;
        go        = state == IDLE && key_flag && !done;
        frame_end = in_frame && phase == PH_HOLD && cnt == HOLD_END;
        start     = in_frame && phase == PH_SETUP && cnt == SETUP_END;
        load      = go || (state == GAP && cnt == GAP_END) || frame_end;
        load_data = state == IDLE ? CMD_WREN : state == GAP ? CMD_BE : 8'h00;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            phase <= PH_SETUP;
            cnt   <= '0;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                state <= WREN_FRM;
                phase <= PH_SETUP;
                cnt   <= '0;
                cs_n  <= 1'b0;
                busy  <= 1'b1;
            end else if (state == GAP) begin
                if (cnt == GAP_END) begin
                    state <= BE_FRM;
                    phase <= PH_SETUP;
                    cnt   <= '0;
                    cs_n  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (in_frame) begin
                if (phase == PH_SETUP) begin
                    if (start) begin
                        phase <= PH_SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else if (phase == PH_SHIFT) begin
                    if (byte_done) phase <= PH_HOLD;
                end else if (frame_end) begin
                    cs_n  <= 1'b1;
                    cnt   <= '0;
                    state <= state == WREN_FRM ? GAP : IDLE;
                    busy  <= state == WREN_FRM;
                    done  <= state == BE_FRM;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load),
        .start     (start),
        .data      (load_data),
        .sck       (sck),
        .mosi      (mosi),
        .byte_done (byte_done)
    );
endmodule

// File: tb/tb_flash_be_ctrl.sv
// tb_flash_be_ctrl: scoreboard bench for flash_be_ctrl at default and minimum timing parameters
module tb_flash_be_ctrl;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [1:0] key;
    logic [1:0] cs_n, sck, mosi, busy, done;

    int n_checks = 0, n_fail = 0, viol = 0, cyc = 0;
    int q[$];
    int exp_done[2], dones[2], lowcnt[2], hicnt[2], since_fall[2], rises[2], first_rise[2], frames[2], t0[2];
    logic [7:0] shreg[2];
    logic prev_cs[2], prev_sck[2], prev_mosi[2];

    always #10 sys_clk = ~sys_clk;

    flash_be_ctrl dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key[0]),
        .cs_n(cs_n[0]), .sck(sck[0]), .mosi(mosi[0]), .busy(busy[0]), .done(done[0])
    );

    flash_be_ctrl #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key[1]),
        .cs_n(cs_n[1]), .sck(sck[1]), .mosi(mosi[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // protocol and frame monitor; the byte scoreboard is popped at every cs_n rise
    always @(negedge sys_clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int lo, gp, su, dv, hd, e;
            lo = i ? 18 : 36;
            gp = i ? 1 : 4;
            su = i ? 1 : 2;
            dv = i ? 1 : 2;
            hd = i ? 1 : 2;
            if (!sys_rst_n) begin
                frames[i] = 0; lowcnt[i] = 0; hicnt[i] = 0; rises[i] = 0; since_fall[i] = 0;
                prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_mosi[i] = 1'b0;
            end else begin
                if (cs_n[i] && (sck[i] || mosi[i])) viol++;
                if (prev_sck[i] && sck[i] && mosi[i] != prev_mosi[i]) viol++;
                if (done[i]) dones[i]++;
                if (prev_cs[i] && !cs_n[i]) begin
                    if (frames[i] % 2 == 1) check("gap_len", hicnt[i], gp);
                    else begin
                        t0[i] = cyc;
                        check("busy_start", busy[i], 1);
                    end
                    lowcnt[i] = 0; rises[i] = 0; first_rise[i] = 0;
                end
                if (!prev_cs[i] && cs_n[i]) begin
                    e = q.size() > 0 ? q.pop_front() : -1;
                    check("byte", i * 256 + int'(shreg[i]), e);
                    check("low_len", lowcnt[i], lo);
                    check("sck_rises", rises[i], 8);
                    check("setup", first_rise[i], su + dv + 1);
                    check("hold", since_fall[i], hd);
                    frames[i]++;
                    if (frames[i] % 2 == 0) begin
                        check("done_pulse", done[i], 1);
                        check("t_done", cyc - t0[i], 2 * lo + gp);
                    end
                    hicnt[i] = 0;
                end
                if (busy[i] != (!cs_n[i] || frames[i] % 2 == 1)) viol++;
                if (!cs_n[i]) begin
                    lowcnt[i]++;
                    if (!prev_sck[i] && sck[i]) begin
                        rises[i]++;
                        shreg[i] = {shreg[i][6:0], mosi[i]};
                        if (rises[i] == 1) first_rise[i] = lowcnt[i];
                    end
                end else begin
                    hicnt[i]++;
                end
                since_fall[i] = sck[i] ? 0 : since_fall[i] + 1;
                prev_cs[i] = cs_n[i]; prev_sck[i] = sck[i]; prev_mosi[i] = mosi[i];
            end
        end
    end

    task automatic pulse(input int i, input int len);
        @(posedge sys_clk); #1;
        key[i] = 1'b1;
        repeat (len) @(posedge sys_clk);
        #1 key[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        bit seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge sys_clk);
            if (done[i]) seen = 1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    // mode 0 plain, 1 extra keys while busy, 2 key held 5 cycles, 3 key on the done cycle
    task automatic run_seq(input int i, input int mode);
        q.push_back(i * 256 + 8'h06);
        q.push_back(i * 256 + 8'hC7);
        pulse(i, mode == 2 ? 5 : 1);
        if (mode == 1) begin
            repeat (9) @(posedge sys_clk);
            pulse(i, 1);
            repeat (38) @(posedge sys_clk);
            pulse(i, 1);
        end
        wait_done(i);
        exp_done[i]++;
        if (mode == 3) begin
            key[i] = 1'b1;
            @(posedge sys_clk);
            #1 key[i] = 1'b0;
        end
        repeat (100) @(posedge sys_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sys_rst_n = 1'b0;
        key = '0;
        exp_done = '{0, 0};
        dones = '{0, 0};
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_cs_n", cs_n[0], 1);
        check("rst_sck", sck[0], 0);
        check("rst_mosi", mosi[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_cs_n1", cs_n[1], 1);
        sys_rst_n = 1'b1;
        run_seq(0, 0);
        run_seq(0, 1);
        run_seq(0, 2);
        run_seq(0, 3);
        q.push_back(8'h06);
        q.push_back(8'hC7);
        pulse(0, 1);
        repeat (44) @(posedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1;
        check("arst_cs_n", cs_n[0], 1);
        check("arst_sck", sck[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_mosi", mosi[0], 0);
        check("arst_done", done[0], 0);
        q.delete();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        run_seq(0, 0);
        run_seq(1, 0);
        run_seq(1, 3);
        repeat (20) @(posedge sys_clk);
        check("queue_empty", q.size(), 0);
        check("done_count0", dones[0], exp_done[0]);
        check("done_count1", dones[1], exp_done[1]);
        check("protocol", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flash_be_ctrl.md
Name: flash_be_ctrl

Overview:
Consumes the one-cycle key_flag pulse from the debounced key path and performs a SPI NOR flash bulk erase. The sequence is Write Enable (0x06), a chip-select gap, then Bulk Erase (0xC7), each in its own chip-select frame. It sits between the key debounce stage and the flash pins, driving cs_n/sck/mosi in SPI mode 0, MSB first.

Parameters:
CLK_DIV, 2, sys_clk cycles per SCK half-period (SCK = sys_clk/(2*CLK_DIV)); legal range >=1.
CS_SETUP, 2, sys_clk cycles from cs_n fall to the first sck rise.
CS_HOLD, 2, sys_clk cycles from the last sck fall to the cs_n rise.
CS_GAP, 4, sys_clk cycles cs_n is held high between the WREN and BE frames.

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous, active-low reset
key_flag  in  1  one-cycle erase request from the debounced key
cs_n  out  1  flash chip select, active low
sck  out  1  SPI clock, idle low (mode 0)
mosi  out  1  serial data to flash, MSB first
busy  out  1  high while a sequence is in progress
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; the clock is sys_clk.
- Reset values: cs_n=1, sck=0, mosi=0, busy=0, done=0, state IDLE, all counters 0.
- All outputs are registered. No combinational path from key_flag to any output.
- States: IDLE -> WREN_FRM -> GAP -> BE_FRM -> IDLE.
- IDLE:
  - key_flag is sampled high only in IDLE.
  - On the next edge: state WREN_FRM, cs_n=0, busy=1, mosi=bit7 of 0x06.
  - key_flag is ignored in every other state, including the cycle in which done is high.
- Frame structure (WREN_FRM and BE_FRM):
  - CS_SETUP cycles with sck=0.
  - Then 8 bits. Per bit: sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mosi updates only on the edge where sck goes low, or at frame start for bit7. The flash samples on sck rise.
  - After bit0, sck returns low and stays low for CS_HOLD cycles, then cs_n=1.
  - cs_n low time = CS_SETUP + 16*CLK_DIV + CS_HOLD cycles (36 at defaults).
  - Exactly 8 sck rising edges per frame.
- GAP:
  - cs_n=1, sck=0, mosi=0 for CS_GAP cycles.
  - Then BE_FRM starts with cs_n=0 and mosi=bit7 of 0xC7.
- End of BE_FRM:
  - On the edge cs_n rises: done=1 for one cycle, busy=0, state IDLE, mosi=0.
- Timing at defaults, with t0 = the edge where cs_n first falls (one edge after key_flag is sampled):
  - WREN cs_n low t0..t0+35.
  - Gap t0+36..t0+39.
  - BE cs_n low t0+40..t0+75.
  - done and cs_n rise at t0+76.
- Bit counter is 3 bits. Cycle counters are sized $clog2(max(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP)+1) and count to param-1 then reset. No wrap beyond the terminal value.
- Reset asserted mid-sequence: outputs return to reset values immediately (async). No done pulse. A fresh key_flag is required to restart.
- key_flag asserted for multiple consecutive cycles in IDLE: only the first high cycle starts a sequence. The remainder falls in the busy window and is ignored.

Decomposition:
- Package flash_pkg:
  - CMD_WREN=8'h06, CMD_BE=8'hC7.
  - State encoding constants (IDLE, WREN_FRM, GAP, BE_FRM).
- Sub-module spi_byte_tx:
  - Inputs: start pulse, 8-bit data, CLK_DIV.
  - Outputs: sck, mosi, byte_done.
  - Shifts one byte in mode 0.
- The top level owns cs_n timing, setup/hold/gap counters, the sequencing FSM, and busy/done.

Test Plan:
- Single key_flag pulse at defaults -> cs_n low 36 cycles, high 4, low 36. mosi captured on sck rises reads 0x06 then 0xC7. done pulses once at t0+76. busy high t0..t0+75.
- key_flag pulses at t0+10 and t0+50 during busy -> ignored. Exactly 16 sck rises total and one done.
- key_flag held high for 5 cycles -> exactly one sequence runs. No second sequence starts after done.
- sys_rst_n pulled low at t0+45 (mid-BE) -> cs_n=1, sck=0, busy=0 asynchronously. No done. A new key_flag then produces a full clean sequence.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_GAP=1 -> each frame has cs_n low 18 cycles with 8 sck rises, gap 1 cycle, bytes 0x06/0xC7 correct.
- Protocol checker throughout: sck=0 whenever cs_n=1; mosi stable while sck high; no sck edge within CS_SETUP of cs_n fall or within CS_HOLD of cs_n rise.
